// File: rtl/ems_pkg.sv
// Shared types and helpers for the EMS bubble generator: widths, state encoding,
// bubble record and the saturating LLR adder.
package ems_pkg;

  localparam int LLR_W   = 6;   // LLR_Width + 1
  localparam int Q_W     = 7;   // Q_Width + 1
  localparam int IDX_W   = 4;   // Addr_Width + 1
  localparam int MAX_LLR = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic [LLR_W-1:0] sum;
    logic [Q_W-1:0]   sym;
  } bubble_t;

  // The sum is formed one bit wider so an overflow past max_llr is visible.
  function automatic logic [LLR_W-1:0] sat_add(input logic [LLR_W-1:0] a,
                                               input logic [LLR_W-1:0] b,
                                               input logic [LLR_W-1:0] max_llr);
    logic [LLR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max_llr}) return max_llr;
    return s[LLR_W-1:0];
  endfunction

endpackage

// File: rtl/bubble_min_select.sv
// Combinational Nb-way minimum over the valid bubbles; equal sums resolve to the
// lowest bubble index.
module bubble_min_select
  import ems_pkg::*;
#(
  parameter  int Nb    = 4,
  localparam int SEL_W = (Nb > 1) ? $clog2(Nb) : 1
) (
  input  bubble_t          bubbles [Nb],
  output logic [SEL_W-1:0] win_idx,
  output logic             win_valid
);

  logic [LLR_W-1:0] best;

  // Strict less-than keeps the earlier (lower k) bubble on a tie.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    best      = '0;
    for (int k = 0; k < Nb; k++) begin
      if (bubbles[k].valid && (!win_valid || bubbles[k].sum < best)) begin
        win_valid = 1'b1;
        win_idx   = SEL_W'(k);
        best      = bubbles[k].sum;
      end
    end
  end

endmodule

// File: rtl/ems_bubble_generator.sv
// EMS elementary-step candidate generator: Nb row-walking bubbles merge the
// U x V sum grid into a non-decreasing LLR stream for the duplication filter.
module ems_bubble_generator
  import ems_pkg::*;
#(
  parameter int LLR_Width  = 5,
  parameter int Q_Width    = 6,
  parameter int Nm         = 16,
  parameter int Addr_Width = 3,
  parameter int Nb         = 4,
  parameter int Max_Ops    = 32,
  parameter int Max_LLR    = 31
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Load_Valid,
  input  logic                Load_Sel,
  input  logic [Addr_Width:0] Load_Addr,
  input  logic [LLR_Width:0]  Load_LLR,
  input  logic [Q_Width:0]    Load_Q,
  input  logic                Start,
  input  logic                Filter_Full,
  output logic                Busy,
  output logic                Output_Valid,
  output logic [LLR_Width:0]  Output_LLR,
  output logic [Q_Width:0]    Output_Q,
  output logic                Done
);

  localparam int SEL_W = (Nb > 1) ? $clog2(Nb) : 1;
  localparam int OPS_W = $clog2(Max_Ops + 1);

  logic [LLR_Width:0] u_llr [Nm];
  logic [Q_Width:0]   u_q   [Nm];
  logic [LLR_Width:0] v_llr [Nm];
  logic [Q_Width:0]   v_q   [Nm];

  state_t           state, next_state;
  bubble_t          bub      [Nb];
  bubble_t          init_bub [Nb];
  bubble_t          win_bub, adv_bub;
  logic [SEL_W-1:0] win_idx;
  logic             win_valid;
  logic             any_after;
  logic             emit;
  logic [OPS_W-1:0] ops;

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && Load_Valid) begin
      if (!Load_Sel) begin
        u_llr[Load_Addr] <= Load_LLR;
        u_q[Load_Addr]   <= Load_Q;
      end else begin
        v_llr[Load_Addr] <= Load_LLR;
        v_q[Load_Addr]   <= Load_Q;
      end
    end
  end

  bubble_min_select #(.Nb(Nb)) u_min_select (
    .bubbles   (bub),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  always_comb begin
    for (int k = 0; k < Nb; k++) begin
      init_bub[k].valid = 1'b1;
      init_bub[k].row   = IDX_W'(k);
      init_bub[k].col   = '0;
      init_bub[k].sum   = sat_add(u_llr[k], v_llr[0], LLR_W'(Max_LLR));
      init_bub[k].sym   = u_q[k] ^ v_q[0];
    end
  end

  // Winner steps one column right; leaving the last column retires it.
  always_comb begin
    win_bub = '0;
    for (int k = 0; k < Nb; k++) begin
      if (SEL_W'(k) == win_idx) win_bub = bub[k];
    end
    adv_bub       = win_bub;
    adv_bub.col   = win_bub.col + 1'b1;
    adv_bub.valid = (win_bub.col != IDX_W'(Nm - 1));
    adv_bub.sum   = sat_add(u_llr[win_bub.row], v_llr[adv_bub.col], LLR_W'(Max_LLR));
    adv_bub.sym   = u_q[win_bub.row] ^ v_q[adv_bub.col];
    any_after     = 1'b0;
    for (int k = 0; k < Nb; k++) begin
      any_after = any_after | ((SEL_W'(k) == win_idx) ? adv_bub.valid : bub[k].valid);
    end
  end

  always_comb begin
    next_state = state;
    emit       = 1'b0;
    case (state)
      ST_IDLE:  if (Start) next_state = ST_INIT;
      ST_INIT:  next_state = ST_RUN;
      ST_RUN: begin
        if (Filter_Full || !win_valid) begin
          next_state = ST_DRAIN;
        end else begin
          emit = 1'b1;
          if (ops + OPS_W'(1) == OPS_W'(Max_Ops) || !any_after) next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < Nb; k++) bub[k].valid <= 1'b0;
    end else if (state == ST_INIT) begin
      for (int k = 0; k < Nb; k++) bub[k] <= init_bub[k];
    end else if (emit) begin
      for (int k = 0; k < Nb; k++) begin
        if (SEL_W'(k) == win_idx) bub[k] <= adv_bub;
      end
    end
  end

  // Busy/Done are registered decodes of the next state so they track it glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Output_Valid <= 1'b0;
      Output_LLR   <= '0;
      Output_Q     <= '0;
      ops          <= '0;
    end else begin
      state        <= next_state;
      Busy         <= (next_state != ST_IDLE);
      Done         <= (next_state == ST_DRAIN);
      Output_Valid <= emit;
      if (emit) begin
        Output_LLR <= win_bub.sum;
        Output_Q   <= win_bub.sym;
      end
      if (state == ST_INIT) ops <= '0;
      else if (emit)        ops <= ops + OPS_W'(1);
    end
  end

endmodule

// File: tb/tb_ems_bubble_generator.sv
// Scoreboard bench: three generator configurations share one load bus; each has
// its own expected-output queue drained by a negedge monitor.
module tb_ems_bubble_generator;

  logic             clk = 1'b0;
  logic [2:0]       rst_n, lv, start, ff;
  logic             lsel;
  logic [3:0]       laddr;
  logic [5:0]       lllr;
  logic [6:0]       lq;
  logic [2:0]       busy, ov, done;
  logic [2:0][5:0]  ollr;
  logic [2:0][6:0]  oq;

  int checks = 0;
  int errors = 0;
  int done_cnt [3] = '{0, 0, 0};
  logic [12:0] expq [3][$];
  logic [12:0] mon_e;

  int su_llr [3][16];
  int su_q   [3][16];
  int sv_llr [3][16];
  int sv_q   [3][16];

  always #5 clk = ~clk;

  // A: Nb=4 Max_Ops=32, B: Nb=1 Max_Ops=32, C: Nb=4 Max_Ops=5
  ems_bubble_generator #(.Nb(4), .Max_Ops(32)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .Load_Valid(lv[0]), .Load_Sel(lsel), .Load_Addr(laddr),
    .Load_LLR(lllr), .Load_Q(lq), .Start(start[0]), .Filter_Full(ff[0]), .Busy(busy[0]),
    .Output_Valid(ov[0]), .Output_LLR(ollr[0]), .Output_Q(oq[0]), .Done(done[0]));
  ems_bubble_generator #(.Nb(1), .Max_Ops(32)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .Load_Valid(lv[1]), .Load_Sel(lsel), .Load_Addr(laddr),
    .Load_LLR(lllr), .Load_Q(lq), .Start(start[1]), .Filter_Full(ff[1]), .Busy(busy[1]),
    .Output_Valid(ov[1]), .Output_LLR(ollr[1]), .Output_Q(oq[1]), .Done(done[1]));
  ems_bubble_generator #(.Nb(4), .Max_Ops(5)) dut_c (
    .clk(clk), .rst_n(rst_n[2]), .Load_Valid(lv[2]), .Load_Sel(lsel), .Load_Addr(laddr),
    .Load_LLR(lllr), .Load_Q(lq), .Start(start[2]), .Filter_Full(ff[2]), .Busy(busy[2]),
    .Output_Valid(ov[2]), .Output_LLR(ollr[2]), .Output_Q(oq[2]), .Done(done[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i]) done_cnt[i]++;
      if (ov[i]) begin
        checks++;
        if (expq[i].size() == 0) begin
          errors++;
          $display("FAIL out%0d unexpected: got llr=%0d q=%0h, expected no valid output",
                   i, ollr[i], oq[i]);
        end else begin
          mon_e = expq[i].pop_front();
          if ({ollr[i], oq[i]} !== mon_e) begin
            errors++;
            $display("FAIL out%0d stream: got llr=%0d q=%0h, expected llr=%0d q=%0h",
                     i, ollr[i], oq[i], mon_e[12:7], mon_e[6:0]);
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic load(input logic [2:0] mask, input logic sel, input int addr,
                      input int llr, input int q);
    lv = mask; lsel = sel; laddr = addr[3:0]; lllr = llr[5:0]; lq = q[6:0];
    tick();
    lv = '0;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        if (!sel) begin su_llr[i][addr] = llr; su_q[i][addr] = q; end
        else      begin sv_llr[i][addr] = llr; sv_q[i][addr] = q; end
      end
    end
  endtask

  // Expected order: all (row,col) pairs of the first nb rows sorted by
  // (saturated sum, row, col), truncated to take entries.
  task automatic push_model(input int inst, input int nb, input int take);
    int s [64];
    int y [64];
    bit used [64];
    int n, best;
    n = nb * 16;
    for (int r = 0; r < nb; r++) begin
      for (int c = 0; c < 16; c++) begin
        s[r*16+c] = su_llr[inst][r] + sv_llr[inst][c];
        if (s[r*16+c] > 31) s[r*16+c] = 31;
        y[r*16+c] = su_q[inst][r] ^ sv_q[inst][c];
        used[r*16+c] = 1'b0;
      end
    end
    if (take > n) take = n;
    for (int t = 0; t < take; t++) begin
      best = -1;
      for (int x = 0; x < n; x++) begin
        if (!used[x] && (best < 0 || s[x] < s[best])) best = x;
      end
      used[best] = 1'b1;
      expq[inst].push_back({s[best][5:0], y[best][6:0]});
    end
  endtask

  task automatic start_run(input logic [2:0] mask);
    start = mask;
    tick();
    start = '0;
  endtask

  task automatic wait_done(input int inst, input int target, input int budget);
    int cyc;
    cyc = 0;
    while (done_cnt[inst] < target && cyc < budget) begin
      tick();
      cyc++;
    end
    checks++;
    if (done_cnt[inst] < target) begin
      errors++;
      $display("FAIL done%0d timeout: got %0d pulses, expected %0d", inst, done_cnt[inst], target);
    end
    tick(2);
    chk($sformatf("busy%0d idle", inst), busy[inst], 1'b0);
  endtask

  initial begin
    rst_n = '0; lv = '0; start = '0; ff = '0;
    lsel = 1'b0; laddr = '0; lllr = '0; lq = '0;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst ov%0d", i),   ov[i],   1'b0);
      chk($sformatf("rst busy%0d", i), busy[i], 1'b0);
      chk($sformatf("rst done%0d", i), done[i], 1'b0);
      chk($sformatf("rst llr%0d", i),  ollr[i], 6'd0);
      chk($sformatf("rst q%0d", i),    oq[i],   7'd0);
    end
    rst_n = '1;
    tick();

    for (int i = 0; i < 16; i++) begin
      load(3'b111, 1'b0, i, i, i);
      load(3'b111, 1'b1, i, 2 * i, 2 * i);
    end

    // Concurrent runs; A also gets a stray Start and a load while busy.
    push_model(0, 4, 32);
    push_model(1, 1, 32);
    push_model(2, 4, 5);
    start_run(3'b111);
    chk("busy after start", busy, 3'b111);
    tick(3);
    start = 3'b001; lv = 3'b001; lsel = 1'b0; laddr = 4'd0; lllr = 6'd9; lq = 7'h11;
    tick();
    start = '0; lv = '0;
    wait_done(2, 1, 100);
    chk("c hold llr", ollr[2], 6'd3);
    chk("c hold q",   oq[2],   7'd3);
    wait_done(1, 1, 100);
    wait_done(0, 1, 100);
    chk("a single done", done_cnt[0], 1);

    push_model(0, 4, 32);
    start_run(3'b001);
    wait_done(0, 2, 100);

    // Filter_Full sampled at the end of the fifth RUN cycle.
    push_model(0, 4, 4);
    start_run(3'b001);
    tick(5);
    ff[0] = 1'b1;
    tick();
    ff[0] = 1'b0;
    chk("ff done", done[0], 1'b1);
    chk("ff ov",   ov[0],   1'b0);
    chk("ff busy", busy[0], 1'b1);
    tick();
    chk("ff done fall", done[0], 1'b0);
    chk("ff busy fall", busy[0], 1'b0);
    tick(3);
    chk("ff q empty", expq[0].size(), 0);
    chk("ff done count", done_cnt[0], 3);

    // Reset asserted during the third RUN cycle.
    push_model(0, 4, 2);
    start_run(3'b001);
    tick(3);
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    chk("mid rst ov",   ov[0],   1'b0);
    chk("mid rst busy", busy[0], 1'b0);
    chk("mid rst done", done[0], 1'b0);
    tick();
    chk("mid rst q empty", expq[0].size(), 0);
    push_model(0, 4, 32);
    start_run(3'b001);
    wait_done(0, 4, 100);

    // Saturation and GF symbol addition on C, row 0 wins every tie at 31.
    for (int i = 0; i < 16; i++) begin
      load(3'b100, 1'b0, i, (30 + i > 31) ? 31 : 30 + i, (i == 0) ? 'h55 : i);
      load(3'b100, 1'b1, i, (20 + i > 31) ? 31 : 20 + i, (i == 0) ? 'h0F : i);
    end
    expq[2].push_back({6'd31, 7'h5A});
    expq[2].push_back({6'd31, 7'h54});
    expq[2].push_back({6'd31, 7'h57});
    expq[2].push_back({6'd31, 7'h56});
    expq[2].push_back({6'd31, 7'h51});
    start_run(3'b100);
    wait_done(2, 2, 100);

    tick(3);
    for (int i = 0; i < 3; i++) chk($sformatf("q%0d empty", i), expq[i].size(), 0);
    chk("b done count", done_cnt[1], 1);
    chk("c done count", done_cnt[2], 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
